// File: rtl/alu_pipe.sv
// alu_pipe: two-stage integer ALU feeding the ROB writeback broadcast.
//   Stage 1 registers the issued operation; stage 2 computes the result and
//   registers it onto the alu_wb_* outputs (latency of two ready cycles).
// Optional feature: define ALU_MUL_EN to add op 16 (MUL, low 32 bits).
//   Without the macro, no multiplier exists and op 16 is reported illegal.
module alu_pipe #(
    parameter int OP_W  = 5,
    parameter int IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             alu_valid,
    input  logic [31:0]      alu_r1,
    input  logic [31:0]      alu_r2,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [IDX_W-1:0] alu_rob_idx,
    output logic             alu_wb_valid,
    output logic [IDX_W-1:0] alu_wb_idx,
    output logic [31:0]      alu_wb_value,
    output logic             illegal_op
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(15);
`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(16);
`endif

    // Stage 1 registers
    logic             r_vld_p1;
    logic [OP_W-1:0]  r_op_p1;
    logic [31:0]      r_r1_p1;
    logic [31:0]      r_r2_p1;
    logic [IDX_W-1:0] r_idx_p1;

    // Stage 2 registers (drive the writeback outputs directly)
    logic             r_wb_vld_p2;
    logic [IDX_W-1:0] r_wb_idx_p2;
    logic [31:0]      r_wb_val_p2;
    logic             r_ill_p2;

    logic signed [31:0] w_r1_s;
    logic signed [31:0] w_r2_s;
    logic [4:0]         w_shamt;
    logic               w_lt_s;
    logic               w_lt_u;
    logic [31:0]        w_result;
    logic               w_illegal;

    assign w_r1_s  = r_r1_p1;
    assign w_r2_s  = r_r2_p1;
    assign w_shamt = r_r2_p1[4:0];
    assign w_lt_s  = (w_r1_s < w_r2_s);
    assign w_lt_u  = (r_r1_p1 < r_r2_p1);

`ifdef ALU_MUL_EN
    logic [31:0] w_mul;
    assign w_mul = r_r1_p1 * r_r2_p1;
`endif

    // Stage 2 combinational result; unknown op codes yield 0 and flag illegal
    always_comb begin
        w_result  = 32'd0;
        w_illegal = 1'b0;
        case (r_op_p1)
            OP_ADD:  w_result = r_r1_p1 + r_r2_p1;
            OP_SUB:  w_result = r_r1_p1 - r_r2_p1;
            OP_AND:  w_result = r_r1_p1 & r_r2_p1;
            OP_OR:   w_result = r_r1_p1 | r_r2_p1;
            OP_XOR:  w_result = r_r1_p1 ^ r_r2_p1;
            OP_SLL:  w_result = r_r1_p1 << w_shamt;
            OP_SRL:  w_result = r_r1_p1 >> w_shamt;
            OP_SRA:  w_result = w_r1_s >>> w_shamt;
            OP_SLT:  w_result = {31'd0, w_lt_s};
            OP_SLTU: w_result = {31'd0, w_lt_u};
            OP_BEQ:  w_result = {31'd0, r_r1_p1 == r_r2_p1};
            OP_BNE:  w_result = {31'd0, r_r1_p1 != r_r2_p1};
            OP_BLT:  w_result = {31'd0, w_lt_s};
            OP_BGE:  w_result = {31'd0, ~w_lt_s};
            OP_BLTU: w_result = {31'd0, w_lt_u};
            OP_BGEU: w_result = {31'd0, ~w_lt_u};
`ifdef ALU_MUL_EN
            OP_MUL:  w_result = w_mul;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // Stage 1 operand capture; data needs no reset, only advances on a live issue
    always_ff @(posedge clk_in) begin
        if (!rob_clear && rdy_in && alu_valid) begin
            r_op_p1  <= alu_op;
            r_r1_p1  <= alu_r1;
            r_r2_p1  <= alu_r2;
            r_idx_p1 <= alu_rob_idx;
        end
    end

    // Pipeline control and writeback registers; flush overrides the ready stall
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld_p1    <= 1'b0;
            r_wb_vld_p2 <= 1'b0;
            r_ill_p2    <= 1'b0;
            r_wb_idx_p2 <= '0;
            r_wb_val_p2 <= 32'd0;
        end else if (rob_clear) begin
            r_vld_p1    <= 1'b0;
            r_wb_vld_p2 <= 1'b0;
            r_ill_p2    <= 1'b0;
        end else if (rdy_in) begin
            r_vld_p1    <= alu_valid;
            r_wb_vld_p2 <= r_vld_p1;
            r_ill_p2    <= r_vld_p1 & w_illegal;
            if (r_vld_p1) begin
                r_wb_idx_p2 <= r_idx_p1;
                r_wb_val_p2 <= w_result;
            end
        end
    end

    assign alu_wb_valid = r_wb_vld_p2;
    assign alu_wb_idx   = r_wb_idx_p2;
    assign alu_wb_value = r_wb_val_p2;
    assign illegal_op   = r_ill_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe with a queue-based reference model.
module tb_alu_pipe;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        alu_valid = 1'b0;
    logic [31:0] alu_r1 = 32'd0;
    logic [31:0] alu_r2 = 32'd0;
    logic [4:0]  alu_op = 5'd0;
    logic [3:0]  alu_rob_idx = 4'd0;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_idx;
    logic [31:0] alu_wb_value;
    logic        illegal_op;

    alu_pipe #(.OP_W(5), .IDX_W(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op),
        .alu_rob_idx(alu_rob_idx), .alu_wb_valid(alu_wb_valid), .alu_wb_idx(alu_wb_idx),
        .alu_wb_value(alu_wb_value), .illegal_op(illegal_op)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference semantics straight from the op-code table
    function automatic logic ref_ill(input logic [4:0] op);
        return (op > 5'd16) || (op == 5'd16 && !MUL_ON);
    endfunction

    function automatic logic [31:0] ref_val(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: return (a == b) ? 32'd1 : 32'd0;
            5'd11: return (a != b) ? 32'd1 : 32'd0;
            5'd12: return (sa < sb) ? 32'd1 : 32'd0;
            5'd13: return (sa >= sb) ? 32'd1 : 32'd0;
            5'd14: return (a < b) ? 32'd1 : 32'd0;
            5'd15: return (a >= b) ? 32'd1 : 32'd0;
            5'd16: begin
                prod = longint'(a) * longint'(b);
                return MUL_ON ? prod[31:0] : 32'd0;
            end
            default: return 32'd0;
        endcase
    endfunction

    // Model: pending writebacks tagged with the ready-edge count at which they are due
    typedef struct {
        int unsigned due;
        logic [3:0]  idx;
        logic [31:0] val;
        logic        ill;
    } wb_t;
    wb_t         m_q[$];
    int unsigned m_cnt = 0;
    logic        m_vld = 1'b0;
    logic        m_ill = 1'b0;
    logic [3:0]  m_idx = 4'd0;
    logic [31:0] m_val = 32'd0;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_q.delete();
            m_vld = 1'b0; m_ill = 1'b0; m_idx = 4'd0; m_val = 32'd0;
        end else if (rob_clear) begin
            m_q.delete();
            m_vld = 1'b0; m_ill = 1'b0;
        end else if (rdy_in) begin
            m_cnt++;
            m_vld = 1'b0;
            m_ill = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == m_cnt) begin
                wb_t e;
                e = m_q.pop_front();
                m_vld = 1'b1; m_ill = e.ill; m_idx = e.idx; m_val = e.val;
            end
            if (alu_valid) begin
                wb_t n;
                n.due = m_cnt + 1;
                n.idx = alu_rob_idx;
                n.val = ref_val(alu_op, alu_r1, alu_r2);
                n.ill = ref_ill(alu_op);
                m_q.push_back(n);
            end
        end
    end

    // Every cycle, mid-period, the outputs must match the model
    always @(negedge clk_in) begin
        chk("wb_valid", {31'd0, alu_wb_valid}, {31'd0, m_vld});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
        chk("wb_idx", {28'd0, alu_wb_idx}, {28'd0, m_idx});
        chk("wb_value", alu_wb_value, m_val);
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] idx);
        alu_valid = v; alu_op = op; alu_r1 = a; alu_r2 = b; alu_rob_idx = idx;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] snap_val;
    logic [3:0]  snap_idx;

    initial begin
        vecs.push_back('{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000});
        vecs.push_back('{5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
        vecs.push_back('{5'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F});
        vecs.push_back('{5'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
        vecs.push_back('{5'd5,  32'h00000001, 32'h00000021, 32'h00000002});
        vecs.push_back('{5'd6,  32'h80000000, 32'h0000001F, 32'h00000001});
        vecs.push_back('{5'd7,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF});
        vecs.push_back('{5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        vecs.push_back('{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{5'd10, 32'h00000005, 32'h00000005, 32'h00000001});
        vecs.push_back('{5'd11, 32'h00000005, 32'h00000005, 32'h00000000});
        vecs.push_back('{5'd12, 32'h80000000, 32'h00000000, 32'h00000001});
        vecs.push_back('{5'd13, 32'h00000000, 32'h80000000, 32'h00000001});
        vecs.push_back('{5'd14, 32'h80000000, 32'h00000000, 32'h00000000});
        vecs.push_back('{5'd15, 32'h80000000, 32'h00000000, 32'h00000001});
        vecs.push_back('{5'd16, 32'h00010001, 32'h00010001, MUL_ON ? 32'h00020001 : 32'h0});
        vecs.push_back('{5'd17, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        vecs.push_back('{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});

        // Reset state
        repeat (3) step();
        chk("rst_valid", {31'd0, alu_wb_valid}, 32'd0);
        chk("rst_ill", {31'd0, illegal_op}, 32'd0);
        chk("rst_idx", {28'd0, alu_wb_idx}, 32'd0);
        chk("rst_value", alu_wb_value, 32'd0);
        rst_n_in = 1'b1;
        step();

        // Wrapping ADD, two-cycle latency
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 32'd1, 4'd3);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("add_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("add_idx", {28'd0, alu_wb_idx}, 32'd3);
        chk("add_value", alu_wb_value, 32'd0);

        // SRA then SLTU back to back
        drive(1'b1, 5'd7, 32'h80000000, 32'h24, 4'd1);
        step();
        drive(1'b1, 5'd9, 32'd1, 32'hFFFFFFFF, 4'd2);
        step();
        chk("sra_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("sra_value", alu_wb_value, 32'hF8000000);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("sltu_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("sltu_value", alu_wb_value, 32'd1);

        // BGE -1 >= 0 held through a 3-cycle stall; issues during stall are ignored
        drive(1'b1, 5'd13, 32'hFFFFFFFF, 32'd0, 4'd6);
        step();
        snap_val = alu_wb_value;
        snap_idx = alu_wb_idx;
        rdy_in = 1'b0;
        drive(1'b1, 5'd0, 32'd5, 32'd5, 4'd9);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_valid", {31'd0, alu_wb_valid}, 32'd0);
            chk("stall_value", alu_wb_value, snap_val);
            chk("stall_idx", {28'd0, alu_wb_idx}, {28'd0, snap_idx});
        end
        rdy_in = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("bge_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("bge_idx", {28'd0, alu_wb_idx}, 32'd6);
        chk("bge_value", alu_wb_value, 32'd0);
        step();
        chk("bge_single", {31'd0, alu_wb_valid}, 32'd0);

        // Pin the model against hand-computed results
        foreach (vecs[i]) begin
            chk("model_pin", ref_val(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            chk("model_ill", {31'd0, ref_ill(vecs[i].op)},
                {31'd0, (vecs[i].op > 5'd16) || (vecs[i].op == 5'd16 && !MUL_ON)});
        end

        // Full-throughput stream, then with bubbles between issues
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].b, vecs[i].a, 4'(15 - i));
            step();
            drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
            step();
        end
        step();

        // Flush kills both in-flight and concurrent issues
        drive(1'b1, 5'd0, 32'd1, 32'd1, 4'd4);
        step();
        drive(1'b1, 5'd0, 32'd2, 32'd2, 4'd5);
        rob_clear = 1'b1;
        step();
        chk("flush_n1", {31'd0, alu_wb_valid}, 32'd0);
        rob_clear = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("flush_n2", {31'd0, alu_wb_valid}, 32'd0);

        // Flush while stalled still takes effect
        drive(1'b1, 5'd1, 32'd9, 32'd3, 4'd7);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        rdy_in = 1'b0;
        rob_clear = 1'b1;
        step();
        rdy_in = 1'b1;
        rob_clear = 1'b0;
        step();
        chk("flush_stall_a", {31'd0, alu_wb_valid}, 32'd0);
        step();
        chk("flush_stall_b", {31'd0, alu_wb_valid}, 32'd0);

        // Op 16 depends on the multiplier option
        drive(1'b1, 5'd16, 32'd7, 32'd6, 4'd5);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("mul_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("mul_value", alu_wb_value, MUL_ON ? 32'd42 : 32'd0);
        chk("mul_ill", {31'd0, illegal_op}, MUL_ON ? 32'd0 : 32'd1);
        step();
        chk("ill_clear", {31'd0, illegal_op}, 32'd0);

        // Undefined op code
        drive(1'b1, 5'd20, 32'hDEADBEEF, 32'd1, 4'd8);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("undef_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("undef_value", alu_wb_value, 32'd0);
        chk("undef_ill", {31'd0, illegal_op}, 32'd1);

        // Asynchronous reset mid-writeback
        drive(1'b1, 5'd0, 32'd1, 32'd2, 4'd9);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        step();
        chk("pre_rst_valid", {31'd0, alu_wb_valid}, 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("async_valid", {31'd0, alu_wb_valid}, 32'd0);
        chk("async_idx", {28'd0, alu_wb_idx}, 32'd0);
        chk("async_value", alu_wb_value, 32'd0);
        chk("async_ill", {31'd0, illegal_op}, 32'd0);
        step();
        rst_n_in = 1'b1;
        step();

        // First issue after reset keeps the two-cycle latency
        drive(1'b1, 5'd0, 32'd10, 32'd20, 4'd2);
        step();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        chk("post_rst_early", {31'd0, alu_wb_valid}, 32'd0);
        step();
        chk("post_rst_valid", {31'd0, alu_wb_valid}, 32'd1);
        chk("post_rst_value", alu_wb_value, 32'd30);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
- REQ-001 Parameter OP_W, default 5, operation-code width; matches the reservation station op type width.
- REQ-002 Parameter IDX_W, default 4, ROB index width.
- REQ-003 Port clk_in, input, 1, system clock; all state updates on its rising edge.
- REQ-004 Port rst_n_in, input, 1, reset; asynchronous, active-low.
- REQ-005 Port rdy_in, input, 1, global ready; low freezes the block.
- REQ-006 Port rob_clear, input, 1, synchronous pipeline flush on misprediction.
- REQ-007 Port alu_valid, input, 1, issue valid from the reservation station; there is no backpressure.
- REQ-008 Port alu_r1, input, 32, operand 1.
- REQ-009 Port alu_r2, input, 32, operand 2.
- REQ-010 Port alu_op, input, OP_W, operation code.
- REQ-011 Port alu_rob_idx, input, IDX_W, destination ROB index.
- REQ-012 Port alu_wb_valid, output, 1, result-broadcast valid.
- REQ-013 Port alu_wb_idx, output, IDX_W, ROB index of the result.
- REQ-014 Port alu_wb_value, output, 32, result value.
- REQ-015 Port illegal_op, output, 1, one-cycle pulse coincident with a writeback of an unsupported op.

Function
- REQ-016 Op codes SHALL be as follows.
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is r2[4:0].
  - 8 SLT, 9 SLTU.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 MUL.
- REQ-017 Arithmetic SHALL wrap modulo 2^32.
  - SLT, BLT and BGE compare signed; SLTU, BLTU and BGEU compare unsigned.
  - Compare ops and branch ops produce 32'd1 or 32'd0.
- REQ-018 The block SHALL be a fixed two-stage pipeline.
  - Stage S1 registers valid, op, operands and index.
  - Stage S2 computes the result from S1 and registers the alu_wb_* outputs.
- REQ-019 Latency SHALL be exactly 2 rdy cycles.
  - An issue sampled at edge N appears on alu_wb_* after edge N+1.
  - Stage S2 holds the result for one cycle only.
- REQ-020 The block SHALL accept one issue per cycle with full throughput; back-to-back issues produce back-to-back writebacks in issue order.
- REQ-021 When alu_valid is low at an edge, S1 SHALL capture valid=0; a bubble propagates as alu_wb_valid=0 one edge later.
- REQ-022 When alu_wb_valid is 0, alu_wb_idx and alu_wb_value SHALL hold their last values; consumers ignore them.
- REQ-023 When rdy_in is low, all state SHALL hold, alu_valid SHALL be ignored, and outputs SHALL stay constant.
  - The block resumes without loss when rdy_in returns high.
- REQ-024 When rob_clear is high at an edge and rdy_in is high, S1 and S2 valid bits SHALL be cleared and the concurrent issue SHALL be dropped.
  - alu_wb_valid is 0 in the following cycle.
- REQ-025 When rob_clear is high at an edge and rdy_in is low, the flush SHALL still occur; rob_clear has priority over rdy_in.
- REQ-026 Undefined op codes (17 and above, or 16 when MUL is excluded) SHALL write back value 0 with alu_wb_valid=1 and illegal_op=1 in the same cycle.
- REQ-027 illegal_op SHALL be 0 whenever alu_wb_valid is 0.

Reset
- REQ-028 While rst_n_in is low, the S1 and S2 valid bits, alu_wb_valid, illegal_op, alu_wb_idx and alu_wb_value SHALL all be 0, asynchronously.
- REQ-029 The first issue accepted after reset deassertion SHALL follow REQ-019; reset asserted mid-operation discards every in-flight result.

Configuration
- REQ-030 Macro ALU_MUL_EN defined: op 16 returns the low 32 bits of r1*r2, computed within S2, with the same 2-cycle latency.
- REQ-031 Macro ALU_MUL_EN undefined: no multiplier is synthesised and op 16 is treated per REQ-026.

Verification
- REQ-032 Issue ADD r1=0xFFFFFFFF, r2=1, idx=3 at edge N: alu_wb_valid=1, idx=3, value=0 after edge N+1.
- REQ-033 Issue SRA r1=0x80000000, r2=0x24 then SLTU r1=1, r2=0xFFFFFFFF on consecutive edges: writebacks 0xF8000000 then 1 on consecutive cycles.
- REQ-034 Issue BGE r1=-1, r2=0, then hold rdy_in low for 3 cycles: output frozen during the stall, then value=0, exactly one writeback pulse.
- REQ-035 Issue ops at edges N and N+1, assert rob_clear at edge N+1: no alu_wb_valid after edges N+1 or N+2.
- REQ-036 Issue op 16 with r1=7, r2=6: with ALU_MUL_EN, value=42 and illegal_op=0; without it, value=0 and illegal_op=1.
- REQ-037 Drive rst_n_in low asynchronously while alu_wb_valid=1: outputs go to 0 immediately, before the next clock edge.
